// File: rtl/pc_fetch_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// riscv_fetch_pkg
// Shared types and constants for the fetch-side PC controller.
//   fetch_state_t : controller states (RUN, FLUSH, HALT, TRAP)
//   PC_STEP       : sequential fetch increment in bytes
//   ALIGN_MASK    : value the low two target bits must hold for a word fetch
//   target_ok()   : true when a redirect target is word aligned and fits in
//                   the pc_w-bit instruction address space
// ---------------------------------------------------------------------------
package riscv_fetch_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2,
        TRAP  = 2'd3
    } fetch_state_t;

    localparam int         PC_STEP    = 4;
    localparam logic [1:0] ALIGN_MASK = 2'b00;

    function automatic logic target_ok(input logic [31:0] tgt, input int unsigned pc_w);
        logic [31:0] upper;
        upper = tgt >> pc_w;
        return (tgt[1:0] == ALIGN_MASK) && (upper == 32'd0);
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl_if
// Bundle between the branch/hazard side and the fetch controller.
//   master : drives stall, PcSel, BrPC, halt_req; observes fetch outputs
//   slave  : the fetch controller (consumes requests, drives pc_out, flushes,
//            trap status and the redirect counter)
// ---------------------------------------------------------------------------
interface pc_fetch_ctrl_if #(
    parameter int PC_W  = 9,
    parameter int CNT_W = 16
);
    logic              stall;
    logic              PcSel;
    logic [31:0]       BrPC;
    logic              halt_req;
    logic [PC_W-1:0]   pc_out;
    logic              fetch_valid;
    logic              flush_ifid;
    logic              flush_idex;
    logic              misalign_trap;
    logic [31:0]       trap_pc;
    logic [CNT_W-1:0]  redirect_cnt;

    modport master (
        output stall, PcSel, BrPC, halt_req,
        input  pc_out, fetch_valid, flush_ifid, flush_idex,
               misalign_trap, trap_pc, redirect_cnt
    );

    modport slave (
        input  stall, PcSel, BrPC, halt_req,
        output pc_out, fetch_valid, flush_ifid, flush_idex,
               misalign_trap, trap_pc, redirect_cnt
    );
endinterface

// File: rtl/pc_fetch_ctrl_sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// W-bit up counter that sticks at all-ones.
//   clk   : rising-edge clock
//   clr_n : synchronous active-low clear (wins over inc)
//   inc   : count one event this cycle
//   cnt   : registered count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// pc_fetch_ctrl
// Program-counter owner for the fetch stage. Steps the PC by 4, loads branch
// and jump targets from the branch unit, squashes wrong-path IF/ID and ID/EX
// contents, honours hazard stalls and halt requests, and traps on redirect
// targets that are misaligned or outside the PC_W address space.
//   clk   : core clock, all state on the rising edge
//   reset : synchronous, active low
//   bus   : slave side of pc_fetch_ctrl_if
//           in : stall, PcSel, BrPC, halt_req
//           out: pc_out, fetch_valid, flush_ifid, flush_idex,
//                misalign_trap, trap_pc, redirect_cnt (all registered)
// ---------------------------------------------------------------------------
module pc_fetch_ctrl
    import riscv_fetch_pkg::*;
#(
    parameter int              PC_W     = 9,
    parameter logic [PC_W-1:0] RESET_PC = '0,
    parameter int              CNT_W    = 16
) (
    input  logic           clk,
    input  logic           reset,
    pc_fetch_ctrl_if.slave bus
);
    fetch_state_t    state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fetch_valid_q, fetch_valid_d;
    logic            flush_ifid_q, flush_idex_q, flush_d;
    logic            misalign_trap_q, misalign_trap_d;
    logic [31:0]     trap_pc_q, trap_pc_d;
    logic            cnt_inc;
    logic [CNT_W-1:0] cnt;

    logic [PC_W-1:0] pc_next_seq;
    logic            tgt_good;

    assign pc_next_seq = pc_q + PC_W'(PC_STEP);
    assign tgt_good    = target_ok(bus.BrPC, PC_W);

    always_comb begin
        state_d         = state_q;
        pc_d            = pc_q;
        fetch_valid_d   = fetch_valid_q;
        flush_d         = 1'b0;
        misalign_trap_d = misalign_trap_q;
        trap_pc_d       = trap_pc_q;
        cnt_inc         = 1'b0;

        case (state_q)
            RUN: begin
                if (bus.PcSel && !tgt_good) begin
                    state_d         = TRAP;
                    fetch_valid_d   = 1'b0;
                    flush_d         = 1'b1;
                    misalign_trap_d = 1'b1;
                    trap_pc_d       = bus.BrPC;
                end else if (bus.PcSel) begin
                    // Redirect outranks both stall and halt; a still-pending
                    // halt is picked up on the next RUN cycle.
                    state_d       = FLUSH;
                    pc_d          = bus.BrPC[PC_W-1:0];
                    fetch_valid_d = 1'b1;
                    flush_d       = 1'b1;
                    cnt_inc       = 1'b1;
                end else if (bus.halt_req) begin
                    state_d       = HALT;
                    fetch_valid_d = 1'b0;
                end else if (bus.stall || !fetch_valid_q) begin
                    // !fetch_valid_q only in the first cycle out of reset:
                    // RESET_PC has not been presented as a real fetch yet,
                    // so hold it for one cycle instead of skipping it.
                    fetch_valid_d = 1'b1;
                end else begin
                    pc_d = pc_next_seq;
                end
            end
            FLUSH: begin
                // Branch resolves in EX; the instruction there is now a
                // bubble, so PcSel and halt_req from it are meaningless.
                state_d = RUN;
                if (!bus.stall) begin
                    pc_d = pc_next_seq;
                end
            end
            HALT: begin
                fetch_valid_d = 1'b0;
            end
            TRAP: begin
                fetch_valid_d = 1'b0;
            end
            default: begin
                state_d = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q         <= RUN;
            pc_q            <= RESET_PC;
            fetch_valid_q   <= 1'b0;
            flush_ifid_q    <= 1'b0;
            flush_idex_q    <= 1'b0;
            misalign_trap_q <= 1'b0;
            trap_pc_q       <= 32'd0;
        end else begin
            state_q         <= state_d;
            pc_q            <= pc_d;
            fetch_valid_q   <= fetch_valid_d;
            flush_ifid_q    <= flush_d;
            flush_idex_q    <= flush_d;
            misalign_trap_q <= misalign_trap_d;
            trap_pc_q       <= trap_pc_d;
        end
    end

    sat_counter #(
        .W (CNT_W)
    ) u_redirect_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (cnt_inc),
        .cnt   (cnt)
    );

    assign bus.pc_out        = pc_q;
    assign bus.fetch_valid   = fetch_valid_q;
    assign bus.flush_ifid    = flush_ifid_q;
    assign bus.flush_idex    = flush_idex_q;
    assign bus.misalign_trap = misalign_trap_q;
    assign bus.trap_pc       = trap_pc_q;
    assign bus.redirect_cnt  = cnt;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pc_fetch_ctrl
// Directed vectors for pc_fetch_ctrl (PC_W=9, RESET_PC=0, CNT_W=4 so the
// counter can be driven into saturation). Each vector drives inputs on the
// falling edge and queues the state expected after the next rising edge; a
// monitor samples 1ns after each rising edge and compares.
// ---------------------------------------------------------------------------
module tb_pc_fetch_ctrl;

    localparam int PC_W  = 9;
    localparam int CNT_W = 4;

    typedef struct {
        int               id;
        logic [PC_W-1:0]  pc;
        logic             fv;
        logic             fl;
        logic             tr;
        logic [31:0]      tpc;
        logic [CNT_W-1:0] cnt;
    } exp_t;

    logic clk;
    logic reset;
    int   checks;
    int   failures;
    int   vec_id;
    exp_t exp_q[$];

    pc_fetch_ctrl_if #(.PC_W(PC_W), .CNT_W(CNT_W)) bus ();

    pc_fetch_ctrl #(
        .PC_W     (PC_W),
        .RESET_PC (9'd0),
        .CNT_W    (CNT_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s vec=%0d actual=0x%0h required=0x%0h", name, id, act, req);
        end
    endtask

    // Monitor: the DUT presents a registered result every cycle.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("pc_out",        e.id, 32'(bus.pc_out),        32'(e.pc));
                chk("fetch_valid",   e.id, 32'(bus.fetch_valid),   32'(e.fv));
                chk("flush_ifid",    e.id, 32'(bus.flush_ifid),    32'(e.fl));
                chk("flush_idex",    e.id, 32'(bus.flush_idex),    32'(e.fl));
                chk("misalign_trap", e.id, 32'(bus.misalign_trap), 32'(e.tr));
                chk("trap_pc",       e.id, bus.trap_pc,            e.tpc);
                chk("redirect_cnt",  e.id, 32'(bus.redirect_cnt),  32'(e.cnt));
            end
        end
    end

    task automatic vec(input logic rst, input logic st, input logic ps, input logic [31:0] br,
                       input logic hl, input logic [PC_W-1:0] epc, input logic efv, input logic efl,
                       input logic etr, input logic [31:0] etpc, input logic [CNT_W-1:0] ecnt);
        exp_t e;
        @(negedge clk);
        reset        = rst;
        bus.stall    = st;
        bus.PcSel    = ps;
        bus.BrPC     = br;
        bus.halt_req = hl;
        vec_id++;
        e.id  = vec_id;
        e.pc  = epc;
        e.fv  = efv;
        e.fl  = efl;
        e.tr  = etr;
        e.tpc = etpc;
        e.cnt = ecnt;
        exp_q.push_back(e);
    endtask

    initial begin
        logic [CNT_W-1:0] c;
        checks       = 0;
        failures     = 0;
        vec_id       = 0;
        reset        = 1'b0;
        bus.stall    = 1'b0;
        bus.PcSel    = 1'b0;
        bus.BrPC     = 32'd0;
        bus.halt_req = 1'b0;

        //   rst st ps BrPC      hl  pc      fv fl tr trap_pc  cnt
        // Reset, then sequential fetch 0,4,8,12
        vec(0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 32'h0,   4'd0);
        vec(0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h004, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h008, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h00C, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h010, 1, 0, 0, 32'h0,   4'd0);
        // Redirect at 0x010 to 0x040, one-cycle flush
        vec(1, 0, 1, 32'h40,   0, 9'h040, 1, 1, 0, 32'h0,   4'd1);
        vec(1, 0, 0, 32'h0,    0, 9'h044, 1, 0, 0, 32'h0,   4'd1);
        vec(1, 0, 0, 32'h0,    0, 9'h048, 1, 0, 0, 32'h0,   4'd1);
        // Back-to-back redirect: second lands in FLUSH and is masked
        vec(1, 0, 1, 32'h80,   0, 9'h080, 1, 1, 0, 32'h0,   4'd2);
        vec(1, 0, 1, 32'h100,  0, 9'h084, 1, 0, 0, 32'h0,   4'd2);
        vec(1, 0, 0, 32'h0,    0, 9'h088, 1, 0, 0, 32'h0,   4'd2);
        // Get to 0x020, then stall 3 cycles with redirect on the 2nd
        vec(1, 0, 1, 32'h1C,   0, 9'h01C, 1, 1, 0, 32'h0,   4'd3);
        vec(1, 0, 0, 32'h0,    0, 9'h020, 1, 0, 0, 32'h0,   4'd3);
        vec(1, 1, 0, 32'h0,    0, 9'h020, 1, 0, 0, 32'h0,   4'd3);
        vec(1, 1, 1, 32'h60,   0, 9'h060, 1, 1, 0, 32'h0,   4'd4);
        vec(1, 1, 0, 32'h0,    0, 9'h060, 1, 0, 0, 32'h0,   4'd4);
        vec(1, 0, 0, 32'h0,    0, 9'h064, 1, 0, 0, 32'h0,   4'd4);
        // halt_req with redirect: redirect first, halt on next RUN cycle
        vec(1, 0, 1, 32'h08,   1, 9'h008, 1, 1, 0, 32'h0,   4'd5);
        vec(1, 0, 0, 32'h0,    1, 9'h00C, 1, 0, 0, 32'h0,   4'd5);
        vec(1, 0, 0, 32'h0,    1, 9'h00C, 0, 0, 0, 32'h0,   4'd5);
        vec(1, 0, 1, 32'h40,   0, 9'h00C, 0, 0, 0, 32'h0,   4'd5);
        vec(1, 0, 0, 32'h0,    0, 9'h00C, 0, 0, 0, 32'h0,   4'd5);
        // Reset out of HALT, then misaligned target traps
        vec(0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h004, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 1, 32'h42,   0, 9'h004, 0, 1, 1, 32'h42,  4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h004, 0, 0, 1, 32'h42,  4'd0);
        vec(1, 0, 1, 32'h40,   0, 9'h004, 0, 0, 1, 32'h42,  4'd0);
        // Reset out of TRAP, then out-of-range target traps
        vec(0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 1, 32'h400,  0, 9'h000, 0, 1, 1, 32'h400, 4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h000, 0, 0, 1, 32'h400, 4'd0);
        vec(0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 32'h0,   4'd0);
        // Top-of-space target and silent wrap to 0
        vec(1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 1, 32'h1FC,  0, 9'h1FC, 1, 1, 0, 32'h0,   4'd1);
        vec(1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 32'h0,   4'd1);
        vec(1, 0, 0, 32'h0,    0, 9'h004, 1, 0, 0, 32'h0,   4'd1);
        // Drive the counter into saturation (15 for CNT_W=4)
        c = 4'd1;
        for (int i = 0; i < 15; i++) begin
            if (c != 4'hF) c = c + 4'd1;
            vec(1, 0, 1, 32'h100, 0, 9'h100, 1, 1, 0, 32'h0, c);
            vec(1, 0, 0, 32'h0,   0, 9'h104, 1, 0, 0, 32'h0, c);
        end
        // Saturated redirect, then reset in the middle of FLUSH
        vec(1, 0, 1, 32'h20,   0, 9'h020, 1, 1, 0, 32'h0,   4'd15);
        vec(0, 0, 0, 32'h0,    0, 9'h000, 0, 0, 0, 32'h0,   4'd0);
        vec(1, 0, 0, 32'h0,    0, 9'h000, 1, 0, 0, 32'h0,   4'd0);

        repeat (3) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain pending=%0d required=0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
